// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and default widths for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_ADDR_BITS  = 15;
  localparam int TMO_CNT_W      = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational grant selection, fixed priority or round-robin
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  input  logic                 mode,
  output logic [IDX_W-1:0]     grant,
  output logic                 any_req
);

  int idx;

  // Scans run from lowest to highest priority so the last hit is the winner.
  always_comb begin
    grant   = '0;
    any_req = |req;
    idx     = 0;
    if (mode) begin
      for (int off = NUM_PORTS; off >= 1; off--) begin
        idx = (int'(last_grant) + off) % NUM_PORTS;
        if (req[idx]) begin
          grant = IDX_W'(idx);
        end
      end
    end else begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (req[i]) begin
          grant = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port among several request channels
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int RR_MODE    = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            port_req,
  input  logic [NUM_PORTS-1:0]            port_write,
  input  logic [NUM_PORTS*ADDR_BITS-1:0]  port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata,
  output logic [NUM_PORTS-1:0]            port_rdy,
  output logic [NUM_PORTS-1:0]            port_err,
  output logic [DATA_WIDTH-1:0]           port_rdata,
  output logic                            mem_req,
  output logic                            mem_write,
  output logic [ADDR_BITS-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  input  logic                            mem_valid,
  output logic                            busy
);

  localparam int                   IDX_W    = idx_width(NUM_PORTS);
  localparam logic                 RR_EN    = 1'(RR_MODE != 0);
  localparam logic [IDX_W-1:0]     LAST_RST = IDX_W'(NUM_PORTS - 1);
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [IDX_W-1:0]        pick;
  logic                    any_req;
  logic                    write_q, write_d;
  logic                    err_q, err_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [TMO_CNT_W-1:0]    cnt_q, cnt_d;

  mem_arb_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req        (port_req),
    .last_grant (last_q),
    .mode       (RR_EN),
    .grant      (pick),
    .any_req    (any_req)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    write_d = write_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = pick;
          last_d  = pick;
          write_d = port_write[pick];
          addr_d  = port_addr[pick*ADDR_BITS +: ADDR_BITS];
          wdata_d = port_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A completion landing on the final timeout cycle still counts as success.
        if (mem_valid) begin
          if (!write_q) begin
            rdata_d = mem_rdata;
          end
          cnt_d   = '0;
          state_d = ST_DONE;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          rdata_d = '1;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      write_q <= write_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign mem_req    = (state_q == ST_BUSY);
  assign mem_write  = mem_req & write_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign port_rdata = rdata_q;

  always_comb begin
    port_rdy = '0;
    port_err = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_rdy[i] = (state_q == ST_DONE) && (grant_q == IDX_W'(i));
      port_err[i] = port_rdy[i] & err_q;
    end
  end

endmodule
